// File: rtl/sti_pkg.sv
// Shared definitions for the serial-to-parallel receiver: frame length
// encodings, the length-to-bit-count mapping, the FSM state type and the
// bundle of per-frame configuration bits.
package sti_pkg;

    // cfg_length encodings
    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Per-frame configuration, captured together on the first bit of a frame
    typedef struct packed {
        logic [1:0] length;
        logic       msb;
        logic       fill;
        logic       low;
    } cfg_t;

    // Number of bits N in a frame for a given length code (8..32)
    function automatic logic [5:0] frame_bits(input logic [1:0] length);
        logic [5:0] n;
        case (length)
            LEN_8:   n = 6'd8;
            LEN_16:  n = 6'd16;
            LEN_24:  n = 6'd24;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

    // Index of the final bit of a frame (N-1), fits in the 5-bit counter
    function automatic logic [4:0] last_index(input logic [1:0] length);
        return 5'(frame_bits(length) - 6'd1);
    endfunction

endpackage

// File: rtl/sti_rx_shreg.sv
// 32-bit indexed bit assembler. Each cycle one bit may be written to an
// arbitrary position; a clear request zeroes the whole word in the same
// cycle as the write, so a new frame starts from an all-zero image.
// frame_d_o is the next-state image, i.e. it already contains the bit being
// written this cycle, which lets the owner extract a completed frame without
// waiting an extra cycle.
module sti_rx_shreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        wr_i,
    input  logic [4:0]  pos_i,
    input  logic        bit_i,
    output logic [31:0] frame_d_o
);

    logic [31:0] frame_q;
    logic [31:0] frame_d;

    // Next image: optional clear, then optional single-bit write
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no latch is inferred.
        frame_d = clr_i ? 32'h0000_0000 : frame_q;
        if (wr_i) begin
            frame_d[pos_i] = bit_i;
        end
    end

    // Assembly register update
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this storage is reset explicitly; positions a frame never writes must read as zero.
            frame_q <= 32'h0000_0000;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_d_o = frame_d;

endmodule

// File: rtl/sti_rx.sv
// Serial frame receiver: collects 8/16/24/32-bit frames one bit per cycle
// (LSB- or MSB-first), extracts a 16-bit payload and presents it with a
// one-cycle po_valid pulse. A frame cut short by si_valid dropping gives a
// one-cycle po_err pulse instead and leaves po_data untouched.
// Optional build macro STI_RX_PADCHK_EN: in 24/32-bit modes a completed
// frame with nonzero bits outside the payload window is reported via po_err
// rather than po_valid. Without the macro padding is ignored.
module sti_rx
    import sti_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    input  logic        cfg_end,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        po_err,
    output logic        rx_off
);

    state_t      state_q;
    logic [4:0]  cnt_q;
    cfg_t        cfg_q;
    logic [15:0] po_data_q;
    logic        po_valid_q;
    logic        po_err_q;

    cfg_t        cfg_live;
    cfg_t        cfg_eff;
    logic [4:0]  bit_idx;
    logic [4:0]  eff_last;
    logic [4:0]  wr_pos;
    logic        frame_start;
    logic        frame_done;
    logic [31:0] frame_d;
    logic [15:0] payload;
    logic        pad_err;

    assign cfg_live = '{length: cfg_length, msb: cfg_msb, fill: cfg_fill, low: cfg_low};

    // Bit placement: on the first bit the live configuration applies,
    // afterwards the configuration captured at frame start
    always_comb begin
        cfg_eff = cfg_q;
        bit_idx = cnt_q;
        if (state_q == IDLE) begin
            cfg_eff = cfg_live;
            bit_idx = 5'd0;
        end
        eff_last = last_index(cfg_eff.length);
        wr_pos   = cfg_eff.msb ? (eff_last - bit_idx) : bit_idx;
    end

    assign frame_start = (state_q == IDLE) && si_valid;
    assign frame_done  = (state_q == RECV) && si_valid && (cnt_q == eff_last);

    sti_rx_shreg u_shreg (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (frame_start),
        .wr_i      (si_valid),
        .pos_i     (wr_pos),
        .bit_i     (si_data),
        .frame_d_o (frame_d)
    );

    // Payload window selection from the frame image including the final bit
    always_comb begin
        payload = frame_d[15:0];
        case (cfg_q.length)
            LEN_8:   payload = cfg_q.low ? {frame_d[7:0], 8'h00} : {8'h00, frame_d[7:0]};
            LEN_16:  payload = frame_d[15:0];
            LEN_24:  payload = cfg_q.fill ? frame_d[23:8] : frame_d[15:0];
            default: payload = cfg_q.fill ? frame_d[31:16] : frame_d[15:0];
        endcase
    end

`ifdef STI_RX_PADCHK_EN
    // Padding check: any set bit outside the payload window marks the frame
    // malformed (bits above N are always zero since the image is cleared)
    always_comb begin
        pad_err = 1'b0;
        case (cfg_q.length)
            LEN_24:  pad_err = cfg_q.fill ? (|frame_d[7:0])  : (|frame_d[23:16]);
            LEN_32:  pad_err = cfg_q.fill ? (|frame_d[15:0]) : (|frame_d[31:16]);
            default: pad_err = 1'b0;
        endcase
    end
`else
    assign pad_err = 1'b0;
`endif

    // Receive FSM with registered payload and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            cfg_q      <= '0;
            po_data_q  <= 16'h0000;
            po_valid_q <= 1'b0;
            po_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            po_valid_q <= 1'b0;
            po_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (si_valid) begin
                        cfg_q   <= cfg_live;
                        cnt_q   <= 5'd1;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (!si_valid) begin
                        // Partial frame abandoned; payload output keeps its value
                        po_err_q <= 1'b1;
                        cnt_q    <= 5'd0;
                        state_q  <= IDLE;
                    end else if (frame_done) begin
                        cnt_q   <= 5'd0;
                        state_q <= IDLE;
                        if (pad_err) begin
                            po_err_q <= 1'b1;
                        end else begin
                            po_valid_q <= 1'b1;
                            po_data_q  <= payload;
                        end
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign po_data  = po_data_q;
    assign po_valid = po_valid_q;
    assign po_err   = po_err_q;
    assign rx_off   = cfg_end & ~si_valid & (state_q == IDLE) & ~po_valid_q;

endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx. A driver sends directed and random frames,
// pushing the expected response (kind, payload, cycle of appearance) into a
// scoreboard queue; a monitor pops and compares whenever the DUT pulses
// po_valid or po_err. Honours STI_RX_PADCHK_EN in its reference model.
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        si_data = 1'b0;
    logic        si_valid = 1'b0;
    logic [1:0]  cfg_length = 2'b00;
    logic        cfg_msb = 1'b0;
    logic        cfg_fill = 1'b0;
    logic        cfg_low = 1'b0;
    logic        cfg_end = 1'b0;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_err;
    logic        rx_off;

`ifdef STI_RX_PADCHK_EN
    localparam bit PADCHK = 1'b1;
`else
    localparam bit PADCHK = 1'b0;
`endif

    sti_rx dut (
        .clk        (clk),
        .rst        (rst),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_fill   (cfg_fill),
        .cfg_low    (cfg_low),
        .cfg_end    (cfg_end),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_err     (po_err),
        .rx_off     (rx_off)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_good = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        si_data  = 1'($urandom);
        repeat (n) tick();
    endtask

    function automatic int nbits(input logic [1:0] l);
        return 8 * (int'(l) + 1);
    endfunction

    // Payload as the frame table defines it, from the integer frame value
    function automatic logic [15:0] model_payload(input logic [1:0] l, input bit fill,
                                                  input bit low, input logic [31:0] f);
        case (nbits(l))
            8:       return low ? 16'((f & 32'hFF) << 8) : 16'(f & 32'hFF);
            16:      return 16'(f);
            24:      return fill ? 16'(f >> 8) : 16'(f);
            default: return fill ? 16'(f >> 16) : 16'(f);
        endcase
    endfunction

    // A padded frame is malformed if it differs from its payload put back in place
    function automatic bit model_pad_bad(input logic [1:0] l, input bit fill, input logic [31:0] f);
        int n;
        int shift;
        n = nbits(l);
        if (!PADCHK || n < 24) return 1'b0;
        shift = fill ? n - 16 : 0;
        return f != (32'(model_payload(l, fill, 1'b0, f)) << shift);
    endfunction

    // Send one frame; abort_at in 1..N-1 drops si_valid before that bit, -1 for none
    task automatic send_frame(input logic [1:0] l, input bit msb, input bit fill, input bit low,
                              input logic [31:0] f, input int abort_at);
        int          n;
        logic [31:0] fm;
        logic [15:0] pl;
        n  = nbits(l);
        fm = (n == 32) ? f : (f & ((32'd1 << n) - 32'd1));
        cfg_length = l;
        cfg_msb    = msb;
        cfg_fill   = fill;
        cfg_low    = low;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                si_valid = 1'b0;
                si_data  = 1'($urandom);
                sb.push_back('{1'b1, last_good, cyc + 1});
                tick();
                return;
            end
            si_valid = 1'b1;
            si_data  = msb ? fm[n-1-k] : fm[k];
            if (k == n - 1) begin
                pl = model_payload(l, fill, low, fm);
                if (model_pad_bad(l, fill, fm)) begin
                    sb.push_back('{1'b1, last_good, cyc + 1});
                end else begin
                    sb.push_back('{1'b0, pl, cyc + 1});
                    last_good = pl;
                end
            end
            tick();
        end
    endtask

    // Monitor: compare every output pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (rst !== 1'b1 && (po_valid || po_err)) begin
            check("valid_err_exclusive", 32'(po_valid & po_err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_output", {30'd0, po_valid, po_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {31'd0, po_err}, {31'd0, e.is_err});
                check("po_data", {16'd0, po_data}, {16'd0, e.data});
                check("pulse_cycle", 32'(cyc), 32'(e.stamp));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  l;
        logic [31:0] f;
        bit          fill;
        int          n;
        int          ab;

        // Reset state
        tick(); tick(); tick();
        check("reset_po_data", {16'd0, po_data}, 32'd0);
        check("reset_po_valid", {31'd0, po_valid}, 32'd0);
        check("reset_po_err", {31'd0, po_err}, 32'd0);
        check("reset_rx_off_no_end", {31'd0, rx_off}, 32'd0);

        // First bit in the cycle right after reset falls; 16-bit MSB-first
        rst = 1'b0;
        send_frame(2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_A5C3, -1);
        // 8-bit LSB-first, high then low placement
        send_frame(2'b00, 1'b0, 1'b0, 1'b1, 32'h3C, -1);
        idle(2);
        send_frame(2'b00, 1'b0, 1'b0, 1'b0, 32'h3C, -1);
        idle(1);
        // Two 32-bit frames back-to-back, upper-half payload
        send_frame(2'b11, 1'b1, 1'b1, 1'b0, 32'h1234_0000, -1);
        send_frame(2'b11, 1'b1, 1'b1, 1'b0, 32'hBEEF_0000, -1);
        idle(2);
        // 24-bit abort after 10 bits, then a full frame
        send_frame(2'b10, 1'b1, 1'b1, 1'b0, 32'h00_5A5A_00, 10);
        send_frame(2'b10, 1'b1, 1'b1, 1'b0, 32'h00_1357_00, -1);
        idle(1);
        // Nonzero padding: error with the check built in, else payload ABCD
        send_frame(2'b10, 1'b1, 1'b1, 1'b0, 32'h00_ABCD_01, -1);
        idle(1);

        // Random traffic: all lengths/orders, gaps, back-to-back and aborts
        for (int i = 0; i < 300; i++) begin
            l    = 2'($urandom_range(0, 3));
            n    = nbits(l);
            fill = 1'($urandom);
            f    = $urandom;
            if (n >= 24 && $urandom_range(0, 1) == 1)
                f = fill ? ((f & 32'hFFFF) << (n - 16)) : (f & 32'hFFFF);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, n - 1)) : -1;
            send_frame(l, 1'($urandom), fill, 1'($urandom), f, ab);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        // rx_off held low while the completion pulse is out, high afterwards
        send_frame(2'b00, 1'b1, 1'b0, 1'b0, 32'h96, -1);
        si_valid = 1'b0;
        cfg_end  = 1'b1;
        #0;
        check("rx_off_during_po_valid", {31'd0, rx_off}, 32'd0);
        tick();
        check("rx_off_idle_end", {31'd0, rx_off}, 32'd1);
        cfg_end = 1'b0;
        idle(1);

        // Reset mid-frame: frame discarded silently, then end-of-stream
        cfg_length = 2'b11;
        cfg_msb    = 1'b0;
        cfg_end    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            si_valid = 1'b1;
            si_data  = 1'($urandom);
            tick();
        end
        check("rx_off_mid_frame", {31'd0, rx_off}, 32'd0);
        rst      = 1'b1;
        si_valid = 1'b0;
        tick();
        last_good = 16'h0000;
        check("midreset_po_data", {16'd0, po_data}, 32'd0);
        rst = 1'b0;
        tick();
        check("rx_off_after_reset", {31'd0, rx_off}, 32'd1);
        check("no_err_after_reset", {31'd0, po_err}, 32'd0);
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
